clint_arbiter: RTL and testbench



---
 rtl/clint_arbiter.sv | 118 +++++++++++
 tb/tb_clint_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/clint_arbiter.sv
// clint_arbiter: shares the CLINT slave port between two masters, with separate read and write channels.
// Widths come from the ADDR_WIDTH / SIZE_WIDTH / REG_DATA_WIDTH / BUS_DATA_WIDTH config macros.
// Defaults are used when a macro is not already defined.
// Define CLINT_ARB_FIXED_PRIO_EN for fixed priority, where port 0 always wins.
// Leave it undefined for the default per-channel round-robin.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef SIZE_WIDTH
`define SIZE_WIDTH 3
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef BUS_DATA_WIDTH
`define BUS_DATA_WIDTH 32
`endif

module clint_arbiter (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req0_valid,
    input  logic                       req0_wr,
    input  logic [`ADDR_WIDTH-1:0]     req0_addr,
    input  logic [`SIZE_WIDTH-1:0]     req0_size,
    input  logic [`REG_DATA_WIDTH-1:0] req0_data,
    output logic                       req0_ready,
    output logic                       req0_rsp_valid,
    output logic [`BUS_DATA_WIDTH-1:0] req0_rsp_data,
    input  logic                       req1_valid,
    input  logic                       req1_wr,
    input  logic [`ADDR_WIDTH-1:0]     req1_addr,
    input  logic [`SIZE_WIDTH-1:0]     req1_size,
    input  logic [`REG_DATA_WIDTH-1:0] req1_data,
    output logic                       req1_ready,
    output logic                       req1_rsp_valid,
    output logic [`BUS_DATA_WIDTH-1:0] req1_rsp_data,
    output logic [`ADDR_WIDTH-1:0]     bus_clint_read_addr,
    output logic [`SIZE_WIDTH-1:0]     bus_clint_read_size,
    output logic                       bus_clint_rd,
    output logic [`ADDR_WIDTH-1:0]     bus_clint_write_addr,
    output logic [`SIZE_WIDTH-1:0]     bus_clint_write_size,
    output logic [`REG_DATA_WIDTH-1:0] bus_clint_data,
    output logic                       bus_clint_wr,
    input  logic [`BUS_DATA_WIDTH-1:0] clint_bus_data
);
    logic rd_c0, rd_c1, wr_c0, wr_c1;
    logic rd_g0, rd_g1, wr_g0, wr_g1;
    logic rd_pend_q, rd_pend_d, rd_id_q, rd_id_d;

    // Candidates are gated by rst_n so nothing is granted while reset is held.
    assign rd_c0 = rst_n & req0_valid & ~req0_wr;
    assign rd_c1 = rst_n & req1_valid & ~req1_wr;
    assign wr_c0 = rst_n & req0_valid & req0_wr;
    assign wr_c1 = rst_n & req1_valid & req1_wr;

`ifdef CLINT_ARB_FIXED_PRIO_EN
    assign rd_g0 = rd_c0;
    assign wr_g0 = wr_c0;
`else
    logic last_rd_q, last_rd_d, last_wr_q, last_wr_d;
    // On a conflict, port 0 wins unless it was the previous winner.
    assign rd_g0 = rd_c0 & (~rd_c1 | last_rd_q);
    assign wr_g0 = wr_c0 & (~wr_c1 | last_wr_q);

    // Round-robin pointers follow the winner, only on cycles with a grant.
    always_comb begin
        last_rd_d = (rd_g0 | rd_g1) ? rd_g1 : last_rd_q;
        last_wr_d = (wr_g0 | wr_g1) ? wr_g1 : last_wr_q;
    end

    // Pointers reset to 1 so port 0 takes the first conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_rd_q <= 1'b1;
            last_wr_q <= 1'b1;
        end else begin
            last_rd_q <= last_rd_d;
            last_wr_q <= last_wr_d;
        end
    end
`endif
    assign rd_g1 = rd_c1 & ~rd_g0;
    assign wr_g1 = wr_c1 & ~wr_g0;

    assign req0_ready = rd_g0 | wr_g0;
    assign req1_ready = rd_g1 | wr_g1;

    assign bus_clint_rd         = rd_g0 | rd_g1;
    assign bus_clint_read_addr  = rd_g0 ? req0_addr : rd_g1 ? req1_addr : '0;
    assign bus_clint_read_size  = rd_g0 ? req0_size : rd_g1 ? req1_size : '0;
    assign bus_clint_wr         = wr_g0 | wr_g1;
    assign bus_clint_write_addr = wr_g0 ? req0_addr : wr_g1 ? req1_addr : '0;
    assign bus_clint_write_size = wr_g0 ? req0_size : wr_g1 ? req1_size : '0;
    assign bus_clint_data       = wr_g0 ? req0_data : wr_g1 ? req1_data : '0;

    // The pending flag reloads every cycle, so back-to-back reads stream one response per cycle.
    always_comb begin
        rd_pend_d = bus_clint_rd;
        rd_id_d   = bus_clint_rd ? rd_g1 : rd_id_q;
    end

    // Tracks the read in flight and which master owns its response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q <= 1'b0;
            rd_id_q   <= 1'b0;
        end else begin
            rd_pend_q <= rd_pend_d;
            rd_id_q   <= rd_id_d;
        end
    end

    assign req0_rsp_valid = rd_pend_q & ~rd_id_q;
    assign req1_rsp_valid = rd_pend_q & rd_id_q;
    assign req0_rsp_data  = req0_rsp_valid ? clint_bus_data : '0;
    assign req1_rsp_data  = req1_rsp_valid ? clint_bus_data : '0;
endmodule

// File: tb/tb_clint_arbiter.sv
// tb_clint_arbiter: directed checks of grants, bus muxing, response routing and reset.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef SIZE_WIDTH
`define SIZE_WIDTH 3
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef BUS_DATA_WIDTH
`define BUS_DATA_WIDTH 32
`endif

module tb_clint_arbiter;
`ifdef CLINT_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n;
    logic req0_valid, req0_wr, req1_valid, req1_wr;
    logic [`ADDR_WIDTH-1:0] req0_addr, req1_addr;
    logic [`SIZE_WIDTH-1:0] req0_size, req1_size;
    logic [`REG_DATA_WIDTH-1:0] req0_data, req1_data;
    logic req0_ready, req0_rsp_valid, req1_ready, req1_rsp_valid;
    logic [`BUS_DATA_WIDTH-1:0] req0_rsp_data, req1_rsp_data, clint_bus_data;
    logic [`ADDR_WIDTH-1:0] bus_clint_read_addr, bus_clint_write_addr;
    logic [`SIZE_WIDTH-1:0] bus_clint_read_size, bus_clint_write_size;
    logic [`REG_DATA_WIDTH-1:0] bus_clint_data;
    logic bus_clint_rd, bus_clint_wr;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    clint_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_wr(req0_wr), .req0_addr(req0_addr), .req0_size(req0_size),
        .req0_data(req0_data), .req0_ready(req0_ready), .req0_rsp_valid(req0_rsp_valid),
        .req0_rsp_data(req0_rsp_data),
        .req1_valid(req1_valid), .req1_wr(req1_wr), .req1_addr(req1_addr), .req1_size(req1_size),
        .req1_data(req1_data), .req1_ready(req1_ready), .req1_rsp_valid(req1_rsp_valid),
        .req1_rsp_data(req1_rsp_data),
        .bus_clint_read_addr(bus_clint_read_addr), .bus_clint_read_size(bus_clint_read_size),
        .bus_clint_rd(bus_clint_rd), .bus_clint_write_addr(bus_clint_write_addr),
        .bus_clint_write_size(bus_clint_write_size), .bus_clint_data(bus_clint_data),
        .bus_clint_wr(bus_clint_wr), .clint_bus_data(clint_bus_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0_valid = 0; req0_wr = 0; req0_addr = '0; req0_size = '0; req0_data = '0;
        req1_valid = 0; req1_wr = 0; req1_addr = '0; req1_size = '0; req1_data = '0;
    endtask

    task automatic rd0(input logic [31:0] a);
        req0_valid = 1; req0_wr = 0; req0_addr = a; req0_size = 3'b010;
    endtask

    task automatic rd1(input logic [31:0] a);
        req1_valid = 1; req1_wr = 0; req1_addr = a; req1_size = 3'b010;
    endtask

    initial begin
        logic [31:0] prev_data;
        int prev_g;
        int g;
        idle();
        clint_bus_data = 32'hdead_beef;
        rst_n = 0;
        rd0(32'hbff8);
        req1_valid = 1; req1_wr = 1; req1_addr = 32'h4; req1_data = 32'h9;
        #2;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_bus_rd", bus_clint_rd, 0);
        chk("rst_bus_wr", bus_clint_wr, 0);
        chk("rst_raddr", bus_clint_read_addr, 0);
        chk("rst_wdata", bus_clint_data, 0);
        chk("rst_rsp_valid0", req0_rsp_valid, 0);
        chk("rst_rsp_data0", req0_rsp_data, 0);
        tick();
        idle();
        rst_n = 1;
        #1;
        chk("idle_bus_rd", bus_clint_rd, 0);
        chk("idle_bus_wr", bus_clint_wr, 0);
        tick();
        chk("idle_rsp_valid0", req0_rsp_valid, 0);
        chk("idle_rsp_valid1", req1_rsp_valid, 0);
        rd0(32'hbff8);
        #1;
        chk("mtime_ready0", req0_ready, 1);
        chk("mtime_bus_rd", bus_clint_rd, 1);
        chk("mtime_raddr", bus_clint_read_addr, 32'hbff8);
        chk("mtime_rsize", bus_clint_read_size, 3'b010);
        tick();
        idle();
        clint_bus_data = 32'h1234_5678;
        #1;
        chk("mtime_rsp_valid0", req0_rsp_valid, 1);
        chk("mtime_rsp_data0", req0_rsp_data, 32'h1234_5678);
        chk("mtime_rsp_valid1", req1_rsp_valid, 0);
        chk("mtime_bus_rd_after", bus_clint_rd, 0);
        rd1(32'h4000);
        #1;
        chk("p1_ready1", req1_ready, 1);
        chk("p1_raddr", bus_clint_read_addr, 32'h4000);
        tick();
        idle();
        clint_bus_data = 32'h55;
        #1;
        chk("p1_rsp_valid1", req1_rsp_valid, 1);
        chk("p1_rsp_data1", req1_rsp_data, 32'h55);
        chk("p1_rsp_valid0", req0_rsp_valid, 0);
        // Last read winner is port 1, so the conflict starts with port 0.
        rd0(32'h0);
        rd1(32'h4000);
        prev_g = -1;
        prev_data = '0;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) idle();
            clint_bus_data = 32'ha0 + k;
            #1;
            if (prev_g >= 0) begin
                chk("rr_rsp_valid0", req0_rsp_valid, prev_g == 0);
                chk("rr_rsp_valid1", req1_rsp_valid, prev_g == 1);
                chk("rr_rsp_data0", req0_rsp_data, prev_g == 0 ? 32'ha0 + k : 32'h0);
                chk("rr_rsp_data1", req1_rsp_data, prev_g == 1 ? 32'ha0 + k : 32'h0);
            end
            if (k < 4) begin
                g = FIXED ? 0 : k % 2;
                chk("rr_ready0", req0_ready, g == 0);
                chk("rr_ready1", req1_ready, g == 1);
                chk("rr_raddr", bus_clint_read_addr, g == 1 ? 32'h4000 : 32'h0);
                prev_g = g;
            end
            tick();
        end
        // Write conflict: last write winner is still the reset value 1.
        req0_valid = 1; req0_wr = 1; req0_addr = 32'h4000; req0_size = 3'b011; req0_data = 32'h5;
        req1_valid = 1; req1_wr = 1; req1_addr = 32'h4008; req1_size = 3'b011; req1_data = 32'h7;
        #1;
        chk("wc1_ready0", req0_ready, 1);
        chk("wc1_ready1", req1_ready, 0);
        chk("wc1_bus_wr", bus_clint_wr, 1);
        chk("wc1_waddr", bus_clint_write_addr, 32'h4000);
        chk("wc1_wdata", bus_clint_data, 32'h5);
        chk("wc1_bus_rd", bus_clint_rd, 0);
        tick();
        #1;
        chk("wc2_ready0", req0_ready, FIXED);
        chk("wc2_ready1", req1_ready, !FIXED);
        chk("wc2_waddr", bus_clint_write_addr, FIXED ? 32'h4000 : 32'h4008);
        chk("wc2_wdata", bus_clint_data, FIXED ? 32'h5 : 32'h7);
        chk("wc2_no_rsp0", req0_rsp_valid, 0);
        chk("wc2_no_rsp1", req1_rsp_valid, 0);
        tick();
        idle();
        // msip write from port 0 and read of the same address from port 1 in one cycle.
        req0_valid = 1; req0_wr = 1; req0_addr = 32'h0; req0_size = 3'b010; req0_data = 32'h1;
        rd1(32'h0);
        #1;
        chk("rw_ready0", req0_ready, 1);
        chk("rw_ready1", req1_ready, 1);
        chk("rw_bus_wr", bus_clint_wr, 1);
        chk("rw_bus_rd", bus_clint_rd, 1);
        chk("rw_wdata", bus_clint_data, 32'h1);
        chk("rw_wsize", bus_clint_write_size, 3'b010);
        chk("rw_raddr", bus_clint_read_addr, 32'h0);
        tick();
        idle();
        clint_bus_data = 32'h0;
        rd1(32'h0);
        #1;
        chk("rw_rsp_valid1", req1_rsp_valid, 1);
        chk("rw_rsp_data1", req1_rsp_data, 32'h0);
        chk("rw_rsp_valid0", req0_rsp_valid, 0);
        chk("rw2_ready1", req1_ready, 1);
        tick();
        idle();
        clint_bus_data = 32'h1;
        #1;
        chk("rw2_rsp_data1", req1_rsp_data, 32'h1);
        tick();
        // Reset asserted in the cycle after a read grant drops its response.
        rd0(32'h8);
        #1;
        chk("mr_ready0", req0_ready, 1);
        tick();
        idle();
        rst_n = 0;
        clint_bus_data = 32'h77;
        #1;
        chk("mr_rsp_valid0", req0_rsp_valid, 0);
        chk("mr_rsp_data0", req0_rsp_data, 0);
        tick();
        rst_n = 1;
        tick();
        chk("mr_post_rsp_valid0", req0_rsp_valid, 0);
        chk("mr_post_rsp_valid1", req1_rsp_valid, 0);
        tick();
        chk("mr_post2_rsp_valid0", req0_rsp_valid, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
